rtype_exec_stage: RTL and testbench

- Execute stage directly downstream of the button-stepped instruction fetch stage.
- Accepts one 32-bit MIPS instruction word per handshake and decodes R-type (opcode 0) instructions.
- Reads a 32x32 register file, computes in the ALU and writes back.
- Exposes the result, flags and a debug read/write port that the board-level select/LED logic displays byte by byte.

---
 rtl/rtype_exec_stage_pkg.sv | 36 +++
 rtl/rtype_exec_stage_alu.sv | 43 ++++
 rtl/rtype_exec_stage.sv | 102 ++++++++++
 tb/tb_rtype_exec_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rtype_exec_stage_pkg.sv
// rtype_exec_stage_pkg: shared FSM states, R-type field positions and funct codes
package rtype_exec_stage_pkg;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam int OP_HI = 31, OP_LO = 26;
    localparam int RS_HI = 25, RS_LO = 21;
    localparam int RT_HI = 20, RT_LO = 16;
    localparam int RD_HI = 15, RD_LO = 11;
    localparam int SH_HI = 10, SH_LO = 6;
    localparam int FN_HI = 5,  FN_LO = 0;

    function automatic logic funct_ok(input logic [5:0] fn);
        return fn inside {F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_ADD, F_ADDU, F_SUB,
                          F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
    endfunction

endpackage

// File: rtl/rtype_exec_stage_alu.sv
// rtype_alu: combinational R-type ALU with signed overflow for add/sub
import rtype_exec_stage_pkg::*;

module rtype_alu #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] f,
    output logic              of
);

    logic [DATA_W-1:0] sum, dif;

    assign sum = a + b;
    assign dif = a - b;

    // result select and overflow (sub compares against negated b)
    always_comb begin
        f = '0;
        case (funct)
            F_ADD, F_ADDU: f = sum;
            F_SUB, F_SUBU: f = dif;
            F_AND:         f = a & b;
            F_OR:          f = a | b;
            F_XOR:         f = a ^ b;
            F_NOR:         f = ~(a | b);
            F_SLT:         f = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            F_SLTU:        f = {{(DATA_W-1){1'b0}}, a < b};
            F_SLL:         f = b << shamt;
            F_SRL:         f = b >> shamt;
            F_SRA:         f = $signed(b) >>> shamt;
            F_SLLV:        f = b << a[4:0];
            F_SRLV:        f = b >> a[4:0];
            default:       f = '0;
        endcase
        of = (funct == F_ADD) ? (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]) :
             (funct == F_SUB) ? (a[DATA_W-1] != b[DATA_W-1]) && (dif[DATA_W-1] != a[DATA_W-1]) : 1'b0;
    end

endmodule

// File: rtl/rtype_exec_stage.sv
// rtype_exec_stage: four-cycle R-type execute stage with register file and debug port
import rtype_exec_stage_pkg::*;

module rtype_exec_stage #(
    parameter int DATA_W   = 32,
    parameter int RF_DEPTH = 32,
    localparam int AW      = $clog2(RF_DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Inst_valid,
    input  logic [31:0]       Inst_code,
    output logic              Inst_ready,
    output logic [DATA_W-1:0] Result,
    output logic              ZF,
    output logic              OF,
    output logic              Done,
    output logic              Illegal,
    input  logic              Dbg_we,
    input  logic [AW-1:0]     Dbg_addr,
    input  logic [DATA_W-1:0] Dbg_wdata,
    output logic [DATA_W-1:0] Dbg_data
);

    state_t            state, nxt;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a, b, f, alu_f;
    logic              alu_of, legal;
    logic [DATA_W-1:0] rf [RF_DEPTH];
    logic [AW-1:0]     rs, rt, rd;

    assign rs       = ir[RS_HI:RS_LO];
    assign rt       = ir[RT_HI:RT_LO];
    assign rd       = ir[RD_HI:RD_LO];
    assign legal    = (ir[OP_HI:OP_LO] == OP_RTYPE) && funct_ok(ir[FN_HI:FN_LO]);
    assign Dbg_data = (Dbg_addr == '0) ? '0 : rf[Dbg_addr];

    rtype_alu #(.DATA_W(DATA_W)) u_alu (
        .a(a),
        .b(b),
        .shamt(ir[SH_HI:SH_LO]),
        .funct(ir[FN_HI:FN_LO]),
        .f(alu_f),
        .of(alu_of)
    );

    // state register
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= nxt;
    end

    // next state: illegal words bail out of DECODE straight back to IDLE
    always_comb begin
        nxt = (state == IDLE)   ? (Inst_valid ? DECODE : IDLE) :
              (state == DECODE) ? (legal ? EXEC : IDLE) :
              (state == EXEC)   ? WB : IDLE;
    end

    // handshake and status pulses
    always_comb begin
        Inst_ready = (state == IDLE);
        Done       = (state == WB);
        Illegal    = (state == DECODE) && !legal;
    end

    // datapath: IR latch, operand fetch, execute flags, result capture
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            f      <= '0;
            Result <= '0;
            ZF     <= 1'b0;
            OF     <= 1'b0;
        end else begin
            if (state == IDLE && Inst_valid) ir <= Inst_code;
            if (state == DECODE) begin
                a <= rf[rs];
                b <= rf[rt];
            end
            if (state == EXEC) begin
                f  <= alu_f;
                ZF <= (alu_f == '0);
                OF <= alu_of;
            end
            if (state == WB && !OF) Result <= f;
        end
    end

    // register file: debug writes only in IDLE, write-back suppressed on overflow, r0 stays 0
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else begin
            if (state == IDLE && Dbg_we && Dbg_addr != '0) rf[Dbg_addr] <= Dbg_wdata;
            if (state == WB && !OF && rd != '0) rf[rd] <= f;
        end
    end

endmodule

// File: tb/tb_rtype_exec_stage.sv
// tb_rtype_exec_stage: directed self-checking bench for rtype_exec_stage
module tb_rtype_exec_stage;

    logic        Clk = 0, Rst = 1, Inst_valid = 0, Dbg_we = 0;
    logic [31:0] Inst_code = '0, Dbg_wdata = '0;
    logic [4:0]  Dbg_addr = '0;
    logic        Inst_ready, ZF, OF, Done, Illegal;
    logic [31:0] Result, Dbg_data;
    int          errors = 0, checks = 0;

    rtype_exec_stage dut (
        .Clk(Clk), .Rst(Rst), .Inst_valid(Inst_valid), .Inst_code(Inst_code),
        .Inst_ready(Inst_ready), .Result(Result), .ZF(ZF), .OF(OF), .Done(Done),
        .Illegal(Illegal), .Dbg_we(Dbg_we), .Dbg_addr(Dbg_addr),
        .Dbg_wdata(Dbg_wdata), .Dbg_data(Dbg_data)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        Dbg_addr = addr;
        #1;
        check(tag, Dbg_data, exp);
    endtask

    task automatic dbg_write(input logic [4:0] addr, input logic [31:0] d);
        Dbg_we = 1; Dbg_addr = addr; Dbg_wdata = d;
        tick();
        Dbg_we = 0;
    endtask

    task automatic run_inst(input string tag, input logic [31:0] w, input logic ill);
        check({tag, "_ready"}, Inst_ready, 1);
        Inst_valid = 1; Inst_code = w;
        tick();
        Inst_valid = 0;
        check({tag, "_ill_t1"}, Illegal, ill);
        check({tag, "_busy_t1"}, Inst_ready, 0);
        tick();
        if (ill) begin
            check({tag, "_ready_t2"}, Inst_ready, 1);
            check({tag, "_nodone_t2"}, Done, 0);
        end else begin
            check({tag, "_nodone_t2"}, Done, 0);
            tick();
            check({tag, "_done_t3"}, Done, 1);
            tick();
            check({tag, "_ready_t4"}, Inst_ready, 1);
            check({tag, "_done_off_t4"}, Done, 0);
        end
    endtask

    logic [31:0] v_w   [11] = '{32'h00064103, 32'h00064102, 32'h00064100, 32'h00E64004,
                                32'h00E64006, 32'h00C74024, 32'h00C74025, 32'h00C74026,
                                32'h00C74027, 32'h00C94022, 32'h00C94023};
    logic [31:0] v_exp [11] = '{32'hF8000001, 32'h08000001, 32'h00000100, 32'h00080000,
                                32'h00010000, 32'h00000000, 32'h8000001F, 32'h8000001F,
                                32'h7FFFFFE0, 32'h7FFFFFE0, 32'h00000011};
    logic        v_of  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic        v_zf  [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic [31:0] s_w   [3]  = '{32'h00425020, 32'h00225826, 32'h0041602B};

    initial begin
        int acc [3];
        int k;
        tick(); tick();
        Rst = 0;
        check("rst_ready", Inst_ready, 1);
        check("rst_result", Result, 0);
        check("rst_zf", ZF, 0);
        check("rst_of", OF, 0);
        check("rst_done", Done, 0);
        check("rst_illegal", Illegal, 0);
        for (int i = 0; i < 32; i++) rd_check($sformatf("rst_r%0d", i), i[4:0], 0);

        dbg_write(5'd1, 32'h7FFFFFFF);
        dbg_write(5'd2, 32'h00000001);
        run_inst("add_of", 32'h00221820, 0);
        check("add_of_flag", OF, 1);
        check("add_of_result", Result, 0);
        rd_check("add_of_r3", 5'd3, 0);
        run_inst("addu", 32'h00221821, 0);
        rd_check("addu_r3", 5'd3, 32'h80000000);
        check("addu_result", Result, 32'h80000000);
        check("addu_of", OF, 0);
        check("addu_zf", ZF, 0);

        run_inst("sub0", 32'h00422022, 0);
        rd_check("sub0_r4", 5'd4, 0);
        check("sub0_zf", ZF, 1);
        dbg_write(5'd1, 32'hFFFFFFFF);
        run_inst("slt", 32'h0022282A, 0);
        rd_check("slt_r5", 5'd5, 1);
        run_inst("sltu", 32'h0022282B, 0);
        rd_check("sltu_r5", 5'd5, 0);
        check("sltu_zf", ZF, 1);

        dbg_write(5'd6, 32'h80000010);
        dbg_write(5'd7, 32'h0000000F);
        dbg_write(5'd9, 32'h7FFFFFFF);
        for (int i = 0; i < 11; i++) begin
            run_inst($sformatf("vec%0d", i), v_w[i], 0);
            rd_check($sformatf("vec%0d_r8", i), 5'd8, v_exp[i]);
            check($sformatf("vec%0d_result", i), Result, v_exp[i]);
            check($sformatf("vec%0d_of", i), OF, v_of[i]);
            check($sformatf("vec%0d_zf", i), ZF, v_zf[i]);
        end

        run_inst("lw", 32'h8C220000, 1);
        check("lw_result", Result, 32'h00000011);
        check("lw_of", OF, 0);
        check("lw_zf", ZF, 0);
        rd_check("lw_r3", 5'd3, 32'h80000000);
        rd_check("lw_r8", 5'd8, 32'h00000011);
        run_inst("badfn", 32'h00221801, 1);
        rd_check("badfn_r3", 5'd3, 32'h80000000);
        run_inst("or_r0", 32'h00220025, 0);
        rd_check("or_r0_r0", 5'd0, 0);
        check("or_r0_result", Result, 32'hFFFFFFFF);

        Inst_valid = 1; Inst_code = s_w[0]; k = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            if (Inst_ready) begin
                acc[k] = c;
                k++;
                tick();
                if (k < 3) Inst_code = s_w[k];
            end else tick();
        end
        Inst_valid = 0;
        check("stream_count", k, 3);
        if (k == 3) begin
            check("stream_gap1", acc[1] - acc[0], 4);
            check("stream_gap2", acc[2] - acc[1], 4);
        end
        tick(); tick(); tick(); tick();
        rd_check("stream_r10", 5'd10, 32'h00000002);
        rd_check("stream_r11", 5'd11, 32'hFFFFFFFE);
        rd_check("stream_r12", 5'd12, 32'h00000001);

        dbg_write(5'd1, 32'h00000005);
        dbg_write(5'd2, 32'h00000006);
        Inst_valid = 1; Inst_code = 32'h00221821;
        tick();
        Inst_valid = 0;
        tick();
        Rst = 1;
        tick();
        Rst = 0;
        check("rstx_ready", Inst_ready, 1);
        check("rstx_done", Done, 0);
        check("rstx_result", Result, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rstx_nodone%0d", i), Done, 0);
        end
        rd_check("rstx_r3", 5'd3, 0);
        rd_check("rstx_r1", 5'd1, 0);

        Inst_valid = 1; Inst_code = 32'h00007024;
        tick();
        Inst_valid = 0;
        Dbg_we = 1; Dbg_addr = 5'd13; Dbg_wdata = 32'h00001234;
        tick(); tick(); tick();
        Dbg_we = 0;
        check("dbgbusy_ready", Inst_ready, 1);
        rd_check("dbgbusy_r13", 5'd13, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
